// File: rtl/aes_block_sequencer.sv
// Sequences a combinational AES core over a stream of 128-bit blocks.
// The key is loaded and held. Each block is registered into the core,
// and the result is captured after a fixed settle time. The result is then
// returned over a valid/ready handshake. Optional CBC chaining XORs each
// plaintext with the previous ciphertext, or with the IV for the first block.
module aes_block_sequencer #(
  parameter int CORE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     key_in,
  input  logic [127:0]     iv_in,
  input  logic             cbc_en,
  input  logic             key_load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [127:0]     core_data,
  output logic [127:0]     core_key,
  input  logic [127:0]     core_result,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(CORE_LAT);

  state_t       state;
  logic [127:0] chainReg;
  logic         cbcMode;
  logic         keyValid;
  logic [3:0]   waitCnt;

  // A block is accepted only in IDLE with a key present. A key_load in the
  // same cycle wins, so the block waits for the next cycle.
  assign in_ready = (state == IDLE) && keyValid && !key_load;
  assign busy     = (state != IDLE);

  // Sequencer FSM. It handles key load, block launch, settle countdown,
  // result capture and the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      core_data <= '0;
      core_key  <= '0;
      chainReg  <= '0;
      cbcMode   <= 1'b0;
      keyValid  <= 1'b0;
      waitCnt   <= '0;
      blk_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            core_key  <= key_in;
            chainReg  <= iv_in;
            cbcMode   <= cbc_en;
            blk_count <= '0;
            keyValid  <= 1'b1;
          end else if (in_valid && in_ready) begin
            core_data <= cbcMode ? (in_data ^ chainReg) : in_data;
            waitCnt   <= LAT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == 4'd1) begin
            // The core has settled. Capture the result, and keep it as the next chain value.
            out_data  <= core_result;
            chainReg  <= core_result;
            out_valid <= 1'b1;
            blk_count <= blk_count + CNT_W'(1);
            waitCnt   <= '0;
            state     <= HOLD;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer.
// A stand-in core returns the FIPS-197 ciphertext for the FIPS-197 key and
// plaintext. For any other input it returns a keyed scramble.
module tb_aes_block_sequencer;

  localparam int LAT = 2;
  localparam int CW  = 3;

  localparam logic [127:0] FKEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FPT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key_in, iv_in, in_data;
  logic          cbc_en, key_load, in_valid, out_ready;
  logic          in_ready, out_valid, busy;
  logic [127:0]  out_data, core_data, core_key, core_result;
  logic [CW-1:0] blk_count;

  int checks = 0;
  int errors = 0;

  logic [127:0]  expQ[$];
  logic [127:0]  mKey, mChain;
  logic          mCbc;
  logic [CW-1:0] mCount;
  logic [127:0]  cd0, cd1, scratch;

  always #5 clk = ~clk;

  function automatic logic [127:0] fakeCore(input logic [127:0] d, input logic [127:0] k);
    if (d == FPT && k == FKEY) return FCT;
    return ({d[95:0], d[127:96]} ^ k) + 128'h0f1e2d3c4b5a6978;
  endfunction

  assign core_result = fakeCore(core_data, core_key);

  aes_block_sequencer #(.CORE_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in), .cbc_en(cbc_en),
    .key_load(key_load), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .core_data(core_data), .core_key(core_key),
    .core_result(core_result), .busy(busy), .blk_count(blk_count)
  );

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic loadKey(input logic [127:0] k, input logic [127:0] iv, input logic cbc);
    @(posedge clk); #1;
    key_in = k; iv_in = iv; cbc_en = cbc; key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
    mKey = k; mChain = iv; mCbc = cbc; mCount = '0;
  endtask

  // Sends one block, checks launch, latency and result, stalls the consumer
  // for 'hold' cycles, optionally pulses key_load while stalled, then drains.
  task automatic sendBlock(input logic [127:0] d, input int hold, input logic keyPulse,
                           output logic [127:0] cdOut);
    int n;
    logic [127:0] exp, held;
    @(posedge clk); #1;
    in_data = d; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    checkVal("acceptReady", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cdOut = mCbc ? (d ^ mChain) : d;
    exp = fakeCore(cdOut, mKey);
    expQ.push_back(exp);
    mChain = exp;
    mCount = mCount + 1'b1;
    @(negedge clk);
    checkVal("coreData", core_data, cdOut);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    checkVal("latency", 128'(n), 128'(LAT));
    if (expQ.size() == 0) begin
      checkVal("queueEmpty", 128'd1, 128'd0);
    end else begin
      checkVal("outData", out_data, expQ.pop_front());
    end
    checkVal("blkCount", 128'(blk_count), 128'(mCount));
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      if (keyPulse && i == 1) begin key_in = ~mKey; key_load = 1'b1; end
      @(negedge clk);
      key_load = 1'b0;
      checkVal("holdData", out_data, held);
      checkVal("holdValid", 128'(out_valid), 128'd1);
      checkVal("holdInReady", 128'(in_ready), 128'd0);
    end
    if (keyPulse) checkVal("keyIgnored", core_key, mKey);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkVal("drainValid", 128'(out_valid), 128'd0);
    checkVal("drainBusy", 128'(busy), 128'd0);
    checkVal("drainReady", 128'(in_ready), 128'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; key_in = '0; iv_in = '0; cbc_en = 1'b0; key_load = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    mKey = '0; mChain = '0; mCbc = 1'b0; mCount = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstOutValid", 128'(out_valid), 128'd0);
    checkVal("rstCoreKey", core_key, 128'd0);
    checkVal("rstBlkCount", 128'(blk_count), 128'd0);
    rst = 1'b0;

    // T2: no key loaded, so the block must never be accepted.
    in_data = FPT; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready || busy || out_valid) seen++;
    end
    checkVal("noKeyIdle", 128'(seen), 128'd0);
    in_valid = 1'b0;

    // T1 + T3: FIPS ECB vector, with consumer stall and an ignored key_load.
    loadKey(FKEY, 128'd0, 1'b0);
    sendBlock(FPT, 5, 1'b1, cd0);
    checkVal("t1Count", 128'(blk_count), 128'd1);

    // T4: CBC with IV 0, two identical blocks.
    loadKey(FKEY, 128'd0, 1'b1);
    checkVal("cbcCountClr", 128'(blk_count), 128'd0);
    sendBlock(FPT, 0, 1'b0, cd0);
    sendBlock(FPT, 2, 1'b0, cd1);
    checkVal("cbcBlk0Data", cd0, FPT);
    checkVal("cbcBlk1Core", core_data, FPT ^ FCT);
    checkVal("cbcCount", 128'(blk_count), 128'd2);

    // T5: reset while the block is settling.
    @(posedge clk); #1;
    in_data = FPT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("t5InWait", 128'(busy), 128'd1);
    #1 rst = 1'b1;
    #1;
    checkVal("t5OutValid", 128'(out_valid), 128'd0);
    checkVal("t5InReady", 128'(in_ready), 128'd0);
    checkVal("t5BlkCount", 128'(blk_count), 128'd0);
    checkVal("t5CoreKey", core_key, 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expQ.delete();
    mChain = '0; mCount = '0;
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) seen++;
    end
    checkVal("t5NeedKey", 128'(seen), 128'd0);
    in_valid = 1'b0;

    // T6: key_load and in_valid together. The key wins and the block waits.
    @(posedge clk); #1;
    key_in = FKEY; iv_in = '0; cbc_en = 1'b0; key_load = 1'b1;
    in_data = FPT; in_valid = 1'b1;
    @(negedge clk);
    checkVal("t6ReadyLow", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    key_load = 1'b0; in_valid = 1'b0;
    mKey = FKEY; mChain = '0; mCbc = 1'b0; mCount = '0;
    @(negedge clk);
    checkVal("t6NotAccepted", 128'(busy), 128'd0);
    checkVal("t6KeyLoaded", core_key, FKEY);
    sendBlock(FPT, 0, 1'b0, cd0);

    // Counter wraps from all-ones back to zero.
    loadKey(128'hdeadbeef_01234567_89abcdef_cafef00d, 128'd0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      sendBlock(128'($urandom) << 64 | 128'($urandom), 0, 1'b0, scratch);
    end
    checkVal("wrapCount", 128'(blk_count), 128'd0);
    checkVal("queueDrained", 128'(expQ.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
